stack_op_sequencer: RTL and testbench
=====================================

# stack_op_sequencer

Command-driven initiator for the 8-bit LIFO stack: accepts stack-machine operations from the processor control unit over a valid/ready handshake. It issues the matching push/pop/tos strobes to the stack and captures popped data with the stack's one-cycle read latency. It computes ALU results, pushes them back, and returns POP/TOS values to the datapath. It also tracks stack depth, so underflow and overflow are caught before any stack traffic is issued.

## Interface
- DW, 8: data width; must equal the stack data width.
- DEPTH, 256: stack capacity in entries.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  a command is present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_op  in  3  opcode:
  - 0 PUSH, 1 POP, 2 TOS, 3 ADD, 4 SUB, 5 AND, 6 NOT, 7 DUP.
- cmd_imm  in  DW  immediate for PUSH; ignored otherwise.
- res_valid  out  1  one-cycle pulse; res_data is valid (POP/TOS only).
- res_data  out  DW  value returned by POP/TOS; holds last value.
- err  out  1  sticky error flag: underflow or overflow rejected; cleared only by rst.
- depth  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
- stk_push, stk_pop, stk_tos  out  1  stack strobes; at most one high per cycle.
- stk_din  out  DW  data to stack; meaningful only with stk_push.
- stk_dout  in  DW  stack read data, updated on the edge that ends a pop/tos cycle.

## Operation
- States: IDLE, PUSHI, POPA, TOSA, POPB, CAPA, CAPB, PUSHR.
- The opcode and immediate are latched on acceptance (cmd_valid & cmd_ready).
- Stack strobes are Moore decodes of state:
  - stk_push in PUSHI/PUSHR;
  - stk_pop in POPA/POPB;
  - stk_tos in TOSA.
- Sequences after acceptance:
  - PUSH: PUSHI (stk_din=imm) -> IDLE.
  - POP: POPA -> CAPA (res_data<=stk_dout, res_valid<=1) -> IDLE.
  - TOS: TOSA -> CAPA (same as POP, no depth change) -> IDLE.
  - ADD/SUB/AND: POPA -> POPB (opa<=stk_dout, the former top) -> CAPB (opb<=stk_dout) -> PUSHR -> IDLE.
  - NOT: POPA -> CAPA (opa<=stk_dout) -> PUSHR -> IDLE.
  - DUP: TOSA -> CAPA (opa<=stk_dout) -> PUSHR -> IDLE.
- PUSHR data:
  - ADD = opb+opa; SUB = opb−opa (second minus top); AND = opb&opa; NOT = ~opa; DUP = opa.
  - All results are DW bits, modulo 2^DW; carry and borrow are discarded.
- Depth: +1 on each stk_push cycle, −1 on each stk_pop cycle.
- Legality is checked at acceptance against the current depth:
  - POP/TOS/NOT/DUP need depth≥1; ADD/SUB/AND need depth≥2.
  - PUSH needs depth<DEPTH; DUP also needs depth<DEPTH.
- Illegal command: it is still consumed. err<=1, the FSM stays in IDLE, no strobe is issued, and depth is unchanged.
- stk_dout is sampled only in POPB, CAPA and CAPB; its post-reset content is never used.

## Timing
- Reset values: state IDLE, cmd_ready 1, res_valid 0, res_data 0, err 0, depth 0, all strobes 0, stk_din 0, opa/opb 0.
- Reset mid-sequence aborts immediately. Outputs go to reset values without waiting for the edge. The pushed result is lost; stack and sequencer depth both return to 0.
- Command-to-ready latency, with acceptance in cycle 0:
  - PUSH: ready again in cycle 2.
  - POP/TOS: res_valid high in cycle 3, with ready.
  - NOT/DUP: ready in cycle 4.
  - ADD/SUB/AND: ready in cycle 5.
- An illegal command returns ready the next cycle.
- cmd_ready is low while busy. A held cmd_valid is accepted only when the FSM returns to IDLE. Back-to-back commands have no extra bubble.
- A strobe is high for exactly one cycle per stack access.

## Test plan
- PUSH 5, PUSH 3, SUB, POP -> res_data=0x02 with a single res_valid pulse; depth 2,1,0 at the respective ready points.
- PUSH 3, PUSH 5, SUB, POP -> res_data=0xFE (wrap); PUSH 0xFF, PUSH 0x01, ADD, TOS -> 0x00, depth 1.
- PUSH 0xF0, DUP, ADD, TOS -> 0xE0, depth 1; NOT then POP -> 0x1F, depth 0; verify the strobe sequence cycle by cycle against the latency table.
- After reset, issue POP -> err=1, no stk_pop, depth 0, ready next cycle; then PUSH 7 and ADD -> err stays 1, depth 1, TOS returns 7.
- DEPTH pushes (0..255) -> depth=256, err 0. Then PUSH and DUP both set err with no stk_push. Then POP returns 255 and depth is 255.
- PUSH 1, PUSH 2, ADD with rst pulsed during POPB -> all outputs at reset values in the same cycle. After release, cmd_ready=1 and POP sets err.

Source files
------------

// File: rtl/stack_op_sequencer_if.sv
// Command/result and stack-strobe bundle between the control unit, the
// sequencer and the LIFO stack.
interface stack_op_sequencer_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 256
);
    localparam int DPW = $clog2(DEPTH) + 1;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_op;
    logic [DW-1:0]  cmd_imm;
    logic           res_valid;
    logic [DW-1:0]  res_data;
    logic           err;
    logic [DPW-1:0] depth;
    logic           stk_push;
    logic           stk_pop;
    logic           stk_tos;
    logic [DW-1:0]  stk_din;
    logic [DW-1:0]  stk_dout;

    // master: the sequencer itself
    modport master (
        input  cmd_valid, cmd_op, cmd_imm, stk_dout,
        output cmd_ready, res_valid, res_data, err, depth,
               stk_push, stk_pop, stk_tos, stk_din
    );

    // slave: control unit plus stack seen from the other side
    modport slave (
        output cmd_valid, cmd_op, cmd_imm, stk_dout,
        input  cmd_ready, res_valid, res_data, err, depth,
               stk_push, stk_pop, stk_tos, stk_din
    );
endinterface

// File: rtl/stack_op_sequencer.sv
// Stack-machine command sequencer: turns PUSH/POP/TOS/ALU ops into stack
// strobes, tracks depth and rejects underflow/overflow before any traffic.
module stack_op_sequencer #(
    parameter int DW    = 8,
    parameter int DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    stack_op_sequencer_if.master bus
);
    localparam int DPW = $clog2(DEPTH) + 1;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_TOS  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_DUP  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_PUSHI, S_POPA, S_TOSA, S_POPB, S_CAPA, S_CAPB, S_PUSHR
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [DW-1:0]  imm_q, imm_d;
    logic [DW-1:0]  opa_q, opa_d;
    logic [DW-1:0]  opb_q, opb_d;
    logic [DW-1:0]  res_data_q, res_data_d;
    logic           res_valid_q, res_valid_d;
    logic           err_q, err_d;
    logic [DPW-1:0] depth_q, depth_d;

    logic           accept, legal;
    logic           push_s, pop_s, tos_s, ready_s;
    logic [DW-1:0]  din_s, alu_s;

    assign accept = bus.cmd_valid && ready_s;

    // Legality is judged on the depth seen at acceptance, before any strobe.
    always_comb begin
        legal = 1'b1;
        case (bus.cmd_op)
            OP_PUSH:                legal = (depth_q != DPW'(DEPTH));
            OP_POP, OP_TOS, OP_NOT: legal = (depth_q != '0);
            OP_ADD, OP_SUB, OP_AND: legal = (depth_q >= DPW'(2));
            OP_DUP:                 legal = (depth_q != '0) && (depth_q != DPW'(DEPTH));
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            imm_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            depth_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            imm_q       <= imm_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            depth_q     <= depth_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && legal) begin
                    case (bus.cmd_op)
                        OP_PUSH:        state_d = S_PUSHI;
                        OP_TOS, OP_DUP: state_d = S_TOSA;
                        default:        state_d = S_POPA;
                    endcase
                end
            end
            S_PUSHI: state_d = S_IDLE;
            S_POPA:  state_d = (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_AND)
                               ? S_POPB : S_CAPA;
            S_TOSA:  state_d = S_CAPA;
            S_POPB:  state_d = S_CAPB;
            S_CAPA:  state_d = (op_q == OP_POP || op_q == OP_TOS) ? S_IDLE : S_PUSHR;
            S_CAPB:  state_d = S_PUSHR;
            S_PUSHR: state_d = S_IDLE;
        endcase
    end

    // stk_dout reflects the access of the previous cycle, so operands are
    // captured one state after the strobe that fetched them.
    always_comb begin
        op_d        = op_q;
        imm_d       = imm_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        res_data_d  = res_data_q;
        res_valid_d = 1'b0;
        err_d       = err_q;
        if (accept) begin
            op_d  = bus.cmd_op;
            imm_d = bus.cmd_imm;
            if (!legal) err_d = 1'b1;
        end
        if (state_q == S_POPB || (state_q == S_CAPA && (op_q == OP_NOT || op_q == OP_DUP)))
            opa_d = bus.stk_dout;
        if (state_q == S_CAPB)
            opb_d = bus.stk_dout;
        if (state_q == S_CAPA && (op_q == OP_POP || op_q == OP_TOS)) begin
            res_data_d  = bus.stk_dout;
            res_valid_d = 1'b1;
        end
        depth_d = depth_q + (push_s ? DPW'(1) : '0) - (pop_s ? DPW'(1) : '0);
    end

    always_comb begin
        case (op_q)
            OP_ADD:  alu_s = opb_q + opa_q;
            OP_SUB:  alu_s = opb_q - opa_q;
            OP_AND:  alu_s = opb_q & opa_q;
            OP_NOT:  alu_s = ~opa_q;
            default: alu_s = opa_q;
        endcase
    end

    always_comb begin
        ready_s = (state_q == S_IDLE);
        push_s  = (state_q == S_PUSHI) || (state_q == S_PUSHR);
        pop_s   = (state_q == S_POPA) || (state_q == S_POPB);
        tos_s   = (state_q == S_TOSA);
        din_s   = '0;
        if (state_q == S_PUSHI)      din_s = imm_q;
        else if (state_q == S_PUSHR) din_s = alu_s;
    end

    assign bus.cmd_ready = ready_s;
    assign bus.stk_push  = push_s;
    assign bus.stk_pop   = pop_s;
    assign bus.stk_tos   = tos_s;
    assign bus.stk_din   = din_s;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.err       = err_q;
    assign bus.depth     = depth_q;
endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: LIFO stack model on the strobes, queue-based
// reference of the stack machine, directed steps then random commands.
module tb_stack_op_sequencer;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, TOS = 3'd2, ADD = 3'd3;
    localparam logic [2:0] SUB  = 3'd4, AND = 3'd5, NOT = 3'd6, DUP = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stack_op_sequencer_if #(.DW(DW), .DEPTH(DEPTH)) bus ();
    stack_op_sequencer #(.DW(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_q[$];
    logic       ref_err;
    logic [7:0] last_res;

    // LIFO stack with one-cycle read latency
    logic [7:0] smem [DEPTH];
    int         sp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp           <= 0;
            bus.stk_dout <= '0;
        end else if (bus.stk_push) begin
            if (sp < DEPTH) begin
                smem[sp] <= bus.stk_din;
                sp       <= sp + 1;
            end
        end else if (bus.stk_pop) begin
            if (sp > 0) begin
                bus.stk_dout <= smem[sp-1];
                sp           <= sp - 1;
            end
        end else if (bus.stk_tos) begin
            if (sp > 0) bus.stk_dout <= smem[sp-1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},     32'(bus.cmd_ready), 1);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        chk({tag, "_res_data"},  32'(bus.res_data), 0);
        chk({tag, "_err"},       32'(bus.err), 0);
        chk({tag, "_depth"},     32'(bus.depth), 0);
        chk({tag, "_strobes"},   32'({bus.stk_push, bus.stk_pop, bus.stk_tos}), 0);
        chk({tag, "_din"},       32'(bus.stk_din), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        ref_q.delete();
        ref_err = 1'b0;
    endtask

    // Issue one command at a negedge and follow it until ready returns.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] imm);
        int         n, lat, exp_lat, rvc, waitc, ns;
        string      obs, exp_s;
        logic       legal, has_res;
        logic [7:0] a, b, exp_res, exp_din, din_obs;

        waitc = 0;
        while (!bus.cmd_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("ready_at_issue", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_imm   = imm;

        n = ref_q.size();
        case (op)
            PUSH:          legal = (n < DEPTH);
            POP, TOS, NOT: legal = (n >= 1);
            DUP:           legal = (n >= 1) && (n < DEPTH);
            default:       legal = (n >= 2);
        endcase
        has_res = 1'b0; exp_s = ""; exp_lat = 1; exp_din = '0; exp_res = '0;
        if (!legal) ref_err = 1'b1;
        else begin
            case (op)
                PUSH: begin ref_q.push_back(imm); exp_din = imm; exp_s = "U"; exp_lat = 2; end
                POP:  begin exp_res = ref_q.pop_back(); has_res = 1'b1; exp_s = "P-"; exp_lat = 3; end
                TOS:  begin exp_res = ref_q[$]; has_res = 1'b1; exp_s = "T-"; exp_lat = 3; end
                NOT:  begin a = ref_q.pop_back(); exp_din = ~a; ref_q.push_back(exp_din);
                            exp_s = "P-U"; exp_lat = 4; end
                DUP:  begin a = ref_q[$]; exp_din = a; ref_q.push_back(exp_din);
                            exp_s = "T-U"; exp_lat = 4; end
                default: begin
                    a = ref_q.pop_back();
                    b = ref_q.pop_back();
                    exp_din = (op == ADD) ? b + a : (op == SUB) ? b - a : b & a;
                    ref_q.push_back(exp_din);
                    exp_s = "PP-U"; exp_lat = 5;
                end
            endcase
        end

        obs = ""; rvc = 0; lat = 0; din_obs = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus.cmd_valid = 1'b0;
            rvc += int'(bus.res_valid);
            if (bus.cmd_ready) begin lat = k; break; end
            ns = int'(bus.stk_push) + int'(bus.stk_pop) + int'(bus.stk_tos);
            if (ns > 1)            obs = {obs, "X"};
            else if (bus.stk_push) begin obs = {obs, "U"}; din_obs = bus.stk_din; end
            else if (bus.stk_pop)  obs = {obs, "P"};
            else if (bus.stk_tos)  obs = {obs, "T"};
            else                   obs = {obs, "-"};
        end
        bus.cmd_valid = 1'b0;

        chk("latency", 32'(lat), 32'(exp_lat));
        checks++;
        assert (obs == exp_s) else begin
            errors++;
            $error("FAIL strobe_seq op%0d: got \"%s\" expected \"%s\"", op, obs, exp_s);
        end
        chk("res_valid_pulses", 32'(rvc), 32'(has_res));
        if (has_res) chk("res_data", 32'(bus.res_data), 32'(exp_res));
        if (exp_din != din_obs || exp_s.len() != 0 && exp_s[exp_s.len()-1] == "U")
            chk("stk_din", 32'(din_obs), 32'(exp_din));
        chk("depth", 32'(bus.depth), 32'(ref_q.size()));
        chk("err", 32'(bus.err), 32'(ref_err));
        last_res = bus.res_data;
    endtask

    initial begin
        int r;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_imm   = '0;
        ref_err       = 1'b0;
        last_res      = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("init");
        rst = 1'b0;

        do_cmd(PUSH, 8'h05); do_cmd(PUSH, 8'h03); do_cmd(SUB, 0); do_cmd(POP, 0);
        chk("sub_5_3", 32'(last_res), 32'h02);

        do_cmd(PUSH, 8'h03); do_cmd(PUSH, 8'h05); do_cmd(SUB, 0); do_cmd(POP, 0);
        chk("sub_wrap", 32'(last_res), 32'hFE);
        do_cmd(PUSH, 8'hFF); do_cmd(PUSH, 8'h01); do_cmd(ADD, 0); do_cmd(TOS, 0);
        chk("add_wrap", 32'(last_res), 32'h00);
        chk("add_wrap_depth", 32'(bus.depth), 1);
        do_cmd(POP, 0);

        do_cmd(PUSH, 8'hF0); do_cmd(DUP, 0); do_cmd(ADD, 0); do_cmd(TOS, 0);
        chk("dup_add", 32'(last_res), 32'hE0);
        do_cmd(NOT, 0); do_cmd(POP, 0);
        chk("not_pop", 32'(last_res), 32'h1F);
        do_cmd(AND, 0);
        chk("and_underflow_err", 32'(bus.err), 1);

        pulse_reset();
        for (int i = 0; i < DEPTH; i++) do_cmd(PUSH, 8'(i));
        chk("full_depth", 32'(bus.depth), DEPTH);
        chk("full_no_err", 32'(bus.err), 0);
        do_cmd(PUSH, 8'hAA); do_cmd(DUP, 0);
        chk("overflow_err", 32'(bus.err), 1);
        do_cmd(POP, 0);
        chk("full_pop", 32'(last_res), 32'd255);
        chk("full_pop_depth", 32'(bus.depth), DEPTH - 1);

        pulse_reset();
        do_cmd(POP, 0);
        chk("empty_pop_err", 32'(bus.err), 1);
        do_cmd(PUSH, 8'h07); do_cmd(ADD, 0); do_cmd(TOS, 0);
        chk("tos_after_err", 32'(last_res), 32'h07);

        pulse_reset();
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 10));
            do_cmd((r > 7) ? PUSH : 3'(r), 8'($urandom));
        end

        // reset landing in the middle of an ADD
        pulse_reset();
        do_cmd(PUSH, 8'h01); do_cmd(PUSH, 8'h02);
        bus.cmd_valid = 1'b1; bus.cmd_op = ADD; bus.cmd_imm = '0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("popb_strobe", 32'(bus.stk_pop), 1);
        #1 rst = 1'b1;
        #1 check_reset_outputs("midseq");
        @(negedge clk);
        rst = 1'b0;
        ref_q.delete();
        ref_err = 1'b0;
        do_cmd(POP, 0);
        chk("midseq_pop_err", 32'(bus.err), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
